// File: rtl/frame_1110_pkg.sv
// Shared definitions for the 1110-sync serial framing transmitter.
// State encoding, sync pattern and stuffing run length.
package frame_1110_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        GAP
    } state_t;

    localparam logic [3:0] SYNC_PATTERN = 4'b1110;
    localparam int         SYNC_LEN     = 4;
    localparam int         STUFF_RUN    = 2;

    // Sync bits go out MSB first, idx 0 is the first bit on the line.
    function automatic logic sync_bit(input logic [1:0] idx);
        return SYNC_PATTERN[2'(SYNC_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/frame_1110_tx_piso_shift.sv
// Parallel-load, shift-left register; o_msb is the next payload bit to send.
// Load has priority over shift.
module piso_shift #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_msb
);

    logic [DATA_WIDTH-1:0] r_shreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_shreg[DATA_WIDTH-1];

endmodule

// File: rtl/frame_1110_tx.sv
// Serial framer: sync 1110, zero-stuffed MSB-first payload (never 111), then an idle gap.
// State and d_out are aligned: each cycle d_out shows the bit belonging to the current state.
module frame_1110_tx
    import frame_1110_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDLE_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  d_out,
    output logic                  frame_active,
    output logic                  frame_done
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam int GCW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(IDLE_GAP - 1);

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_sync_cnt, w_sync_cnt_nxt;
    logic [BCW-1:0] r_bit_cnt, w_bit_cnt_nxt, w_bit_inc;
    logic [1:0]     r_run_cnt, w_run_cnt_nxt;
    logic [GCW-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic           r_d_out, w_d_out_nxt;
    logic           r_frame_active, w_frame_active_nxt;
    logic           r_frame_done, w_frame_done_nxt;
    logic           w_load, w_shift, w_emit, w_msb;

    piso_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_piso_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (tx_data),
        .o_msb   (w_msb)
    );

    assign w_bit_inc = r_bit_cnt + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_sync_cnt_nxt   = r_sync_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_run_cnt_nxt    = r_run_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_d_out_nxt      = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        w_emit           = 1'b0;

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_nxt    = SYNC;
                    w_sync_cnt_nxt = '0;
                    w_run_cnt_nxt  = '0;
                    w_bit_cnt_nxt  = '0;
                    w_load         = 1'b1;
                    w_d_out_nxt    = sync_bit(2'd0);
                end
            end
            SYNC: begin
                if (r_sync_cnt == 2'(SYNC_LEN - 1)) begin
                    w_emit = 1'b1;
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt + 2'd1;
                    w_d_out_nxt    = sync_bit(r_sync_cnt + 2'd1);
                end
            end
            DATA: begin
                // A stuff bit due after the last payload bit ends the frame.
                if (r_run_cnt == 2'(STUFF_RUN)) begin
                    w_state_nxt      = STUFF;
                    w_run_cnt_nxt    = '0;
                    w_frame_done_nxt = (r_bit_cnt == LAST_BIT);
                end else if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt   = GAP;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_emit = 1'b1;
                end
            end
            STUFF: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt   = GAP;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_emit = 1'b1;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_emit) begin
            w_state_nxt      = DATA;
            w_shift          = 1'b1;
            w_d_out_nxt      = w_msb;
            w_bit_cnt_nxt    = w_bit_inc;
            w_run_cnt_nxt    = w_msb ? (r_run_cnt + 2'd1) : 2'd0;
            w_frame_done_nxt = (w_bit_inc == LAST_BIT) &&
                               !(w_msb && (r_run_cnt == 2'(STUFF_RUN - 1)));
        end

        w_frame_active_nxt = (w_state_nxt == SYNC) || (w_state_nxt == DATA) ||
                             (w_state_nxt == STUFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_sync_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_run_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_d_out        <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sync_cnt     <= w_sync_cnt_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_run_cnt      <= w_run_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_d_out        <= w_d_out_nxt;
            r_frame_active <= w_frame_active_nxt;
            r_frame_done   <= w_frame_done_nxt;
        end
    end

    assign tx_ready     = (r_state == IDLE);
    assign d_out        = r_d_out;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;

endmodule
